// File: rtl/band_energy_pkg.sv
// Shared types and constants for the band-energy feature extractor.
package band_energy_pkg;

    // Frame-processing states of the extractor.
    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        FLUSH   = 2'd1,
        EMIT    = 2'd2,
        DISCARD = 2'd3
    } state_e;

    localparam int SQ_W       = 32;  // squared bin magnitude
    localparam int ENERGY_W   = 40;  // total-frame energy accumulator
    localparam int BAND_W     = 36;  // per-band energy accumulator
    localparam int LOG_FRAC_W = 10;  // fractional bits of the log2 code
    localparam int FEAT_W     = 16;  // feature width

    // Feature code for zero energy; also the offset that makes the log code signed.
    localparam logic [FEAT_W-1:0] ZERO_FEATURE   = 16'h8000;
    localparam logic [FEAT_W-1:0] FEATURE_OFFSET = 16'h8000;

    // Position of the most significant set bit (0 when e is zero).
    function automatic logic [5:0] lead_one(input logic [ENERGY_W-1:0] e);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < ENERGY_W; i++) begin
            if (e[i]) p = 6'(i);
        end
        return p;
    endfunction

endpackage

// File: rtl/band_energy_extractor_if.sv
// Bin input stream and feature output stream of the extractor.
// Handshake: a beat transfers on every cycle its valid is high; there is no
// ready in either direction, so the sink must take each beat as it comes.
// *_last marks the final beat of a frame and is only meaningful with valid.
interface band_energy_extractor_if;
    logic        [15:0] bin_data_in;
    logic               bin_valid_in;
    logic               bin_last_in;
    logic signed [15:0] feature_data_out;
    logic               feature_valid_out;
    logic               feature_last_out;
    logic               frame_error_out;

    // Bin source / feature sink side.
    modport master (
        output bin_data_in, bin_valid_in, bin_last_in,
        input  feature_data_out, feature_valid_out, feature_last_out, frame_error_out
    );

    // Extractor side.
    modport slave (
        input  bin_data_in, bin_valid_in, bin_last_in,
        output feature_data_out, feature_valid_out, feature_last_out, frame_error_out
    );
endinterface

// File: rtl/log2_approx.sv
// Registered piecewise-linear log2: {leading-one index, 10 bits below it},
// offset to a signed feature. Zero energy maps to the most negative code.
module log2_approx
    import band_energy_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic [ENERGY_W-1:0]      energy_i,
    output logic signed [FEAT_W-1:0] feature_o
);

    logic [5:0]            lead_p;
    logic [LOG_FRAC_W-1:0] frac;
    logic [FEAT_W-1:0]     feature_d;
    logic [FEAT_W-1:0]     feature_q;

    // Shifting {E, 10'b0} right by p puts the leading one at bit 10, so the
    // low 10 bits are the mantissa, zero-padded when p < 10.
    always_comb begin
        lead_p = lead_one(energy_i);
        frac   = LOG_FRAC_W'({energy_i, {LOG_FRAC_W{1'b0}}} >> lead_p);
        if (energy_i == '0) begin
            feature_d = ZERO_FEATURE;
        end else begin
            feature_d = {lead_p, frac} ^ FEATURE_OFFSET;
        end
    end

    // Output register, loaded only while features are being emitted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            feature_q <= '0;
        end else if (en_i) begin
            feature_q <= feature_d;
        end
    end

    assign feature_o = feature_q;

endmodule

// File: rtl/band_energy_extractor.sv
// Turns a frame of FFT bin magnitudes into a 16-entry log-energy vector:
// entry 0 is total frame energy, entries 1..15 the equal-width band energies.
module band_energy_extractor
    import band_energy_pkg::*;
#(
    parameter int NUM_BINS         = 256,
    parameter int NUM_FEATURES_OUT = 16,
    parameter int BINS_PER_BAND    = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    band_energy_extractor_if.slave  bus,
    output state_e                  state_dbg_out
);

    localparam int CNT_W  = $clog2(NUM_BINS);
    localparam int IDX_W  = $clog2(NUM_FEATURES_OUT);
    localparam int BAND_SH = $clog2(BINS_PER_BAND);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BINS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES_OUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q, flush_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ovr_q, ovr_d;        // a bin was dropped during FLUSH/EMIT
    logic               ovr_last_q, ovr_last_d;  // most recent dropped bin was last

    logic               accept;
    logic               clear_acc;
    logic               emit_active;
    logic               emit_last;
    logic               err_d;

    logic [SQ_W-1:0]    sq_q;
    logic               sq_valid_q;
    logic [IDX_W-1:0]   sq_band_q;

    logic [ENERGY_W-1:0] total_q;
    logic [BAND_W-1:0]   band_acc_q [NUM_FEATURES_OUT];  // slot 0 (DC) stays zero
    logic [ENERGY_W-1:0] energy_sel;

    logic               feat_valid_q;
    logic               feat_last_q;
    logic               err_q;
    logic signed [FEAT_W-1:0] feat_data;

    // FSM state register plus bin counter, flush timer and emit index.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            idx_q      <= '0;
            ovr_q      <= 1'b0;
            ovr_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            idx_q      <= idx_d;
            ovr_q      <= ovr_d;
            ovr_last_q <= ovr_last_d;
        end
    end

    // Next-state logic: framing checks, pipeline drain and emit sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        idx_d       = idx_q;
        ovr_d       = ovr_q;
        ovr_last_d  = ovr_last_q;
        accept      = 1'b0;
        clear_acc   = 1'b0;
        emit_active = 1'b0;
        emit_last   = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ACCUM: begin
                if (bus.bin_valid_in) begin
                    if (bus.bin_last_in) begin
                        if (cnt_q == CNT_LAST) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            flush_d = 1'b0;
                            state_d = FLUSH;
                        end else begin
                            // Short frame: drop it and start afresh.
                            err_d     = 1'b1;
                            clear_acc = 1'b1;
                            cnt_d     = '0;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // Too many bins: drop the rest of this frame.
                        err_d     = 1'b1;
                        clear_acc = 1'b1;
                        cnt_d     = '0;
                        state_d   = DISCARD;
                    end else begin
                        accept = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (bus.bin_valid_in) begin
                    ovr_d      = 1'b1;
                    ovr_last_d = bus.bin_last_in;
                end
                flush_d = 1'b1;
                if (flush_q) begin
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                emit_active = 1'b1;
                emit_last   = (idx_q == IDX_LAST);
                if (bus.bin_valid_in) begin
                    ovr_d      = 1'b1;
                    ovr_last_d = bus.bin_last_in;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    clear_acc  = 1'b1;
                    cnt_d      = '0;
                    ovr_d      = 1'b0;
                    ovr_last_d = 1'b0;
                    state_d    = ACCUM;
                    if (ovr_q || bus.bin_valid_in) begin
                        err_d = 1'b1;
                        if (!(bus.bin_valid_in ? bus.bin_last_in : ovr_last_q)) begin
                            state_d = DISCARD;
                        end
                    end
                end
            end
            DISCARD: begin
                if (bus.bin_valid_in && bus.bin_last_in) begin
                    clear_acc = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Square stage; a clear also kills the square in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sq_q       <= '0;
            sq_valid_q <= 1'b0;
            sq_band_q  <= '0;
        end else begin
            sq_q       <= 32'(bus.bin_data_in) * 32'(bus.bin_data_in);
            sq_valid_q <= accept && !clear_acc;
            sq_band_q  <= IDX_W'(cnt_q >> BAND_SH);
        end
    end

    // Accumulate stage: every square into the total, non-DC squares into their band.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            total_q <= '0;
            for (int i = 0; i < NUM_FEATURES_OUT; i++) band_acc_q[i] <= '0;
        end else if (clear_acc) begin
            total_q <= '0;
            for (int i = 0; i < NUM_FEATURES_OUT; i++) band_acc_q[i] <= '0;
        end else if (sq_valid_q) begin
            total_q <= total_q + ENERGY_W'(sq_q);
            if (sq_band_q != '0) begin
                band_acc_q[sq_band_q] <= band_acc_q[sq_band_q] + BAND_W'(sq_q);
            end
        end
    end

    // Feature index 0 reads the total energy, others their band.
    always_comb begin
        energy_sel = ENERGY_W'(band_acc_q[idx_q]);
        if (idx_q == '0) energy_sel = total_q;
    end

    log2_approx u_log2 (
        .clk_i     (clk_in),
        .rst_n_i   (rst_in),
        .en_i      (emit_active),
        .energy_i  (energy_sel),
        .feature_o (feat_data)
    );

    // Output flags, aligned with the registered log2 result.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            feat_valid_q <= 1'b0;
            feat_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            feat_valid_q <= emit_active;
            feat_last_q  <= emit_last;
            err_q        <= err_d;
        end
    end

    assign bus.feature_data_out  = feat_data;
    assign bus.feature_valid_out = feat_valid_q;
    assign bus.feature_last_out  = feat_last_q;
    assign bus.frame_error_out   = err_q;
    assign state_dbg_out         = state_q;

endmodule

// File: tb/tb_band_energy_extractor.sv
// Directed bench for band_energy_extractor: frames in, feature vectors checked
// against hand-computed log2 codes, latency, framing errors and reset abort.
module tb_band_energy_extractor;
    import band_energy_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk_in = 1'b0;
    logic   rst_in = 1'b0;
    state_e dbg_state;
    int     cyc = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    band_energy_extractor_if bus ();

    band_energy_extractor dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bus           (bus),
        .state_dbg_out (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q [$];
    logic [15:0] got_d [$];
    logic        got_l [$];
    int          got_c [$];
    int          err_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_cyc = 0;
    logic [15:0] frame_v [256];

    // Output monitor, sampled away from the active edge.
    always @(negedge clk_in) begin
        if (bus.feature_valid_out === 1'b1) begin
            got_d.push_back(bus.feature_data_out);
            got_l.push_back(bus.feature_last_out);
            got_c.push_back(cyc);
        end
        if (bus.frame_error_out === 1'b1) err_cnt++;
    end

    // ---------------- checker / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bin(input logic [15:0] d, input logic l);
        bus.bin_data_in  = d;
        bus.bin_valid_in = 1'b1;
        bus.bin_last_in  = l;
        if (l) last_cyc = cyc;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) drive_bin(frame_v[i], (i == n - 1));
        bus.bin_valid_in = 1'b0;
        bus.bin_last_in  = 1'b0;
        bus.bin_data_in  = '0;
    endtask

    task automatic fill_frame(input logic [15:0] v);
        for (int i = 0; i < 256; i++) frame_v[i] = v;
    endtask

    task automatic push_exp(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic wait_count(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got_d.size() >= n) break;
            @(posedge clk_in);
        end
    endtask

    task automatic clear_got();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    // Compare one 16-feature vector against exp_q, including latency and contiguity.
    task automatic check_vector(input string tag, input int t_last);
        int c0;
        wait_count(16, 60);
        check({tag, " count"}, got_d.size(), 16);
        c0 = (got_c.size() > 0) ? got_c[0] : 0;
        check({tag, " latency"}, c0 - t_last, 4);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (got_d.size() > 0) begin
                check($sformatf("%s f%0d data", tag, i), got_d.pop_front(), e);
                check($sformatf("%s f%0d last", tag, i), got_l.pop_front(), (i == 15));
                check($sformatf("%s f%0d cycle", tag, i), got_c.pop_front(), c0 + i);
            end
        end
        repeat (5) @(posedge clk_in);
        #1;
        check({tag, " extra"}, got_d.size(), 0);
        clear_got();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int e0;
        int t1;
        bus.bin_data_in  = '0;
        bus.bin_valid_in = 1'b0;
        bus.bin_last_in  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk_in);
        #1;
        check("rst valid", bus.feature_valid_out, 0);
        check("rst last", bus.feature_last_out, 0);
        check("rst data", bus.feature_data_out, 0);
        check("rst err", bus.frame_error_out, 0);
        check("rst state", 32'(dbg_state), 32'(ACCUM));
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("post-rst state", 32'(dbg_state), 32'(ACCUM));
        check("post-rst valid", bus.feature_valid_out, 0);

        // All-zero frame
        fill_frame(16'h0000);
        push_exp(16'h8000, 16);
        send_frame(256);
        check_vector("zero", last_cyc);
        check("zero err", err_cnt, 0);

        // Single tone in bin 16 (first bin of band 1)
        fill_frame(16'h0000);
        frame_v[16] = 16'd1024;
        push_exp(16'hD000, 2);
        push_exp(16'h8000, 14);
        send_frame(256);
        check_vector("tone", last_cyc);

        // Full-scale frame
        fill_frame(16'hFFFF);
        push_exp(16'h1FFF, 1);
        push_exp(16'h0FFF, 15);
        send_frame(256);
        check_vector("fullscale", last_cyc);

        // Band edges: bins 0/15 are DC-only, bin 31 ends band 1, bin 255 ends band 15
        fill_frame(16'h0000);
        frame_v[0]   = 16'd5;
        frame_v[15]  = 16'd1;
        frame_v[31]  = 16'd3;
        frame_v[255] = 16'd2;
        push_exp(16'h94E0, 1);
        push_exp(16'h8C80, 1);
        push_exp(16'h8000, 13);
        push_exp(16'h8800, 1);
        send_frame(256);
        check_vector("edges", last_cyc);

        // Short frame, then a clean zero frame
        e0 = err_cnt;
        fill_frame(16'h0000);
        send_frame(100);
        repeat (30) @(posedge clk_in);
        #1;
        check("short no output", got_d.size(), 0);
        check("short err pulses", err_cnt - e0, 1);
        check("short state", 32'(dbg_state), 32'(ACCUM));
        push_exp(16'h8000, 16);
        send_frame(256);
        check_vector("after short", last_cyc);

        // Overrun: next frame starts right after the last bin
        e0 = err_cnt;
        fill_frame(16'h0000);
        frame_v[16] = 16'd1024;
        send_frame(256);
        t1 = last_cyc;
        send_frame(256);
        push_exp(16'hD000, 2);
        push_exp(16'h8000, 14);
        check_vector("overrun first", t1);
        check("overrun err pulses", err_cnt - e0, 1);
        check("overrun state", 32'(dbg_state), 32'(ACCUM));
        fill_frame(16'h0000);
        push_exp(16'h8000, 16);
        send_frame(256);
        check_vector("after overrun", last_cyc);

        // Reset during emit, after feature 5
        fill_frame(16'h0000);
        send_frame(256);
        wait_count(6, 40);
        check("pre-abort count", got_d.size(), 6);
        #1;
        rst_in = 1'b0;
        #1;
        check("abort valid", bus.feature_valid_out, 0);
        check("abort last", bus.feature_last_out, 0);
        check("abort data", bus.feature_data_out, 0);
        check("abort state", 32'(dbg_state), 32'(ACCUM));
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        repeat (30) @(posedge clk_in);
        #1;
        check("abort residual", got_d.size(), 6);
        clear_got();
        push_exp(16'h8000, 16);
        send_frame(256);
        check_vector("after abort", last_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
